vgm_ay_sequencer: RTL

- Upstream command stage for the YM2149 PSG core.
- Consumes a VGM byte stream through a valid/ready handshake and decodes AY-8910 write, wait and end commands.
- Issues single-cycle register-write pulses (reg, val, wr) that the PSG core edge-detects.
- Paces playback by counting 44.1 kHz sample ticks derived from the system clock.

---
 rtl/vgm_ay_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/vgm_ay_sequencer.sv
// vgm_ay_sequencer: VGM byte-stream decoder driving AY/YM2149 register writes, paced by 44.1 kHz sample waits.
// Optional VGM_SHORT_WAIT_EN: opcodes 0x70..0x7F become 1..16-sample waits.
module vgm_ay_sequencer #(
  parameter int unsigned SAMPLE_DIV = 567
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       out_ready,
  output logic [3:0] out_reg,
  output logic [7:0] out_val,
  output logic       out_wr,
  output logic       out_done,
  output logic       out_err
);
  typedef enum logic [2:0] {S_OPCODE, S_ARG0, S_ARG1, S_WRITE, S_WAIT, S_DONE, S_ERROR} state_t;
  localparam logic [15:0] DIV_MAX = 16'(SAMPLE_DIV - 1);
  state_t      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  reg_q, reg_d;
  logic [7:0]  val_q, val_d;
  logic        acc;
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= S_OPCODE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      reg_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      reg_q   <= reg_d;
      val_q   <= val_d;
    end
  end
  assign acc = in_valid && out_ready;
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    reg_d   = reg_q;
    val_d   = val_q;
    case (state_q)
      S_OPCODE: if (acc) begin
        is_wr_d = in_data == 8'hA0;
        div_d   = '0;
        case (in_data)
          8'hA0, 8'h61: state_d = S_ARG0;
          8'h62: begin cnt_d = 16'd735; state_d = S_WAIT; end
          8'h63: begin cnt_d = 16'd882; state_d = S_WAIT; end
          8'h66: state_d = S_DONE;
`ifdef VGM_SHORT_WAIT_EN
          default: if (in_data[7:4] == 4'h7) begin
            cnt_d   = {12'd0, in_data[3:0]} + 16'd1;
            state_d = S_WAIT;
          end else state_d = S_ERROR;
`else
          default: state_d = S_ERROR;
`endif
        endcase
      end
      S_ARG0: if (acc) begin
        addr_d  = in_data;
        state_d = S_ARG1;
      end
      S_ARG1: if (acc) begin
        // Register value is latched with the strobe so both appear on the same edge.
        if (is_wr_q && addr_q[7:4] == 4'h0) begin
          reg_d = addr_q[3:0];
          val_d = in_data;
        end
        cnt_d   = {in_data, addr_q};
        state_d = is_wr_q ? S_WRITE : S_WAIT;
      end
      S_WRITE: state_d = S_OPCODE;
      S_WAIT: if (cnt_q == 16'd0) state_d = S_OPCODE;
        else if (div_q == DIV_MAX) begin
          div_d = '0;
          cnt_d = cnt_q - 16'd1;
        end else div_d = div_q + 16'd1;
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_OPCODE;
    endcase
  end
  always_comb begin
    out_ready = state_q inside {S_OPCODE, S_ARG0, S_ARG1};
    out_wr    = state_q == S_WRITE && addr_q[7:4] == 4'h0;
    out_done  = state_q == S_DONE;
    out_err   = state_q == S_ERROR;
    out_reg   = reg_q;
    out_val   = val_q;
  end
endmodule
